// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and oversampling constants.
package uart_pkg;

  localparam int unsigned OVERSAMPLE  = 16;
  localparam int unsigned MID_SAMPLE  = 7;
  localparam int unsigned LAST_SAMPLE = 15;
  localparam int unsigned DATA_BITS   = 8;

  localparam int unsigned SCNT_W = $clog2(OVERSAMPLE);
  localparam int unsigned NIDX_W = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator: one-clk pulse every DIV clocks.
module uart_baud_tick #(
  parameter int unsigned DIV = 162
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CW = $clog2(DIV);

  logic [CW-1:0] cnt;

  // tick is registered one count early so it is high exactly while cnt == DIV-1
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (cnt == CW'(DIV - 2));
      cnt  <= (cnt == CW'(DIV - 1)) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 16x oversampled 8N1 with a one-byte holding register.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned clk_freq = 50000000,
  parameter int unsigned baud     = 19200
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 rd_uart,
  output logic [DATA_BITS-1:0] r_data,
  output logic                 rx_empty,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 parity_err
);

  localparam int unsigned DIV = clk_freq / (baud * OVERSAMPLE);

  logic                 tick;
  logic                 rx_meta, rxs, rxs_d;
  rx_state_e            state, state_next;
  logic [SCNT_W-1:0]    s_cnt, s_cnt_next;
  logic [NIDX_W-1:0]    n, n_next;
  logic [DATA_BITS-1:0] shift, shift_next;
  logic                 last_c, mid_c;
  logic                 deliver_c, ferr_set_c, rd_ok_c;
`ifdef UART_RX_PARITY_EN
  logic                 perr_set_c;
`endif

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Two-flop synchronizer plus one delay flop for start-edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rxs_d   <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
      rxs_d   <= rxs;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      s_cnt <= '0;
      n     <= '0;
      shift <= '0;
    end else begin
      state <= state_next;
      s_cnt <= s_cnt_next;
      n     <= n_next;
      shift <= shift_next;
    end
  end

  assign mid_c  = (s_cnt == SCNT_W'(MID_SAMPLE));
  assign last_c = (s_cnt == SCNT_W'(LAST_SAMPLE));

  always_comb begin
    state_next = state;
    s_cnt_next = s_cnt;
    n_next     = n;
    shift_next = shift;
    case (state)
      IDLE: begin
        if (rxs_d && !rxs) begin
          state_next = START;
          s_cnt_next = '0;
        end
      end
      START: begin
        if (tick) begin
          if (mid_c) begin
            s_cnt_next = '0;
            n_next     = '0;
            state_next = rxs ? IDLE : DATA;
          end else begin
            s_cnt_next = s_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (last_c) begin
            s_cnt_next = '0;
            shift_next = {rxs, shift[DATA_BITS-1:1]};
            if (n == NIDX_W'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_next = PARITY;
`else
              state_next = STOP;
`endif
            end else begin
              n_next = n + 1'b1;
            end
          end else begin
            s_cnt_next = s_cnt + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (last_c) begin
            s_cnt_next = '0;
            state_next = STOP;
          end else begin
            s_cnt_next = s_cnt + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (last_c) begin
            s_cnt_next = '0;
            state_next = IDLE;
          end else begin
            s_cnt_next = s_cnt + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Frame-end strobes consumed by the holding register
  always_comb begin
    deliver_c  = 1'b0;
    ferr_set_c = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_set_c = 1'b0;
    if (state == PARITY && tick && last_c && (^{shift, rxs}))
      perr_set_c = 1'b1;
`endif
    if (state == STOP && tick && last_c) begin
      deliver_c  = rxs;
      ferr_set_c = !rxs;
    end
  end

  assign rd_ok_c = rd_uart && !rx_empty;

  // A read in the same cycle as delivery frees the slot, so the new byte loads cleanly
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data    <= '0;
      rx_empty  <= 1'b1;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (deliver_c && (rx_empty || rd_ok_c)) begin
        r_data   <= shift;
        rx_empty <= 1'b0;
      end else if (rd_ok_c) begin
        rx_empty <= 1'b1;
      end
      frame_err <= (frame_err && !rd_ok_c) || ferr_set_c;
      overrun   <= (overrun && !rd_ok_c) || (deliver_c && !rx_empty && !rd_ok_c);
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) parity_err <= 1'b0;
    else      parity_err <= (parity_err && !rd_ok_c) || perr_set_c;
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule
